// File: rtl/ysyx_24110015_bus_pkg.sv
// Shared types and constants for the AXI-lite bus arbiter.
package ysyx_24110015_bus_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;
  localparam int unsigned SIZE_W = 3;
  localparam int unsigned RESP_W = 2;

  localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
  localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    IFU_RD,
    LSU_RD,
    LSU_WR,
    ERR_RESP
  } arb_state_t;

  typedef enum logic {
    MID_IFU,
    MID_LSU
  } master_id_t;

endpackage

// File: rtl/axi_lite_if.sv
// AXI-lite channel bundle: 32-bit address/data, 4-bit strobe, 3-bit size.
interface axi_lite_if;
  import ysyx_24110015_bus_pkg::*;

  logic [ADDR_W-1:0] araddr;
  logic [SIZE_W-1:0] arsize;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [RESP_W-1:0] rresp;
  logic              rvalid;
  logic              rready;
  logic [ADDR_W-1:0] awaddr;
  logic [SIZE_W-1:0] awsize;
  logic              awvalid;
  logic              awready;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wvalid;
  logic              wready;
  logic [RESP_W-1:0] bresp;
  logic              bvalid;
  logic              bready;

  modport master (
    output araddr, arsize, arvalid, rready, awaddr, awsize, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arsize, arvalid, rready, awaddr, awsize, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

endinterface

// File: rtl/ysyx_24110015_bus_watchdog.sv
// Saturating busy-cycle counter; fire_c flags the last allowed cycle of a transaction.
module ysyx_24110015_bus_watchdog #(
  parameter int unsigned TIMEOUT = 4096,
  parameter int unsigned CNT_W   = 13
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic fire_c
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (en && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign fire_c = (TIMEOUT != 0) && en && (cnt_q == CNT_LAST);

endmodule

// File: rtl/ysyx_24110015_axi_arbiter.sv
// Two-master AXI-lite arbiter (IFU read-only, LSU read/write) onto one memory port,
// one transaction at a time, with a watchdog that answers SLVERR on a hung slave.
module ysyx_24110015_axi_arbiter
  import ysyx_24110015_bus_pkg::*;
#(
  parameter int unsigned ROUND_ROBIN = 0,
  parameter int unsigned TIMEOUT     = 4096,
  parameter int unsigned CNT_W       = 13
) (
  input  logic       clk,
  input  logic       rst,
  axi_lite_if.slave  ifu,
  axi_lite_if.slave  lsu,
  axi_lite_if.master mem,
  output logic       timeout_err
);

  arb_state_t state_q, state_d;
  master_id_t grant_q, grant_d, rr_last_q, rr_last_d, winner_c;
  logic       err_wr_q, err_wr_d;
  logic       ifu_req_c, lsu_req_c, busy_c, fire_c;
  logic       rd_done_c, wr_done_c, err_ack_c, err_set_c;
  logic       unused_ifu_wr;

  assign ifu_req_c = ifu.arvalid;
  assign lsu_req_c = lsu.arvalid | lsu.awvalid;
  assign busy_c    = (state_q == IFU_RD) || (state_q == LSU_RD) || (state_q == LSU_WR);
  assign rd_done_c = mem.rvalid & mem.rready;
  assign wr_done_c = mem.bvalid & mem.bready;
  assign err_ack_c = err_wr_q ? lsu.bready : ((grant_q == MID_IFU) ? ifu.rready : lsu.rready);

  // IFU never writes: its write channels stay silent.
  assign ifu.awready   = 1'b0;
  assign ifu.wready    = 1'b0;
  assign ifu.bvalid    = 1'b0;
  assign ifu.bresp     = RESP_OKAY;
  assign unused_ifu_wr = ^{ifu.awaddr, ifu.awsize, ifu.awvalid, ifu.wdata, ifu.wstrb,
                           ifu.wvalid, ifu.bready};

  ysyx_24110015_bus_watchdog #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_wdog (
    .clk    (clk),
    .rst    (rst),
    .clr    (state_q == IDLE),
    .en     (busy_c),
    .fire_c (fire_c)
  );

  // Conflict resolution: LSU by default, or whoever did not win last time.
  always_comb begin
    winner_c = MID_IFU;
    if (lsu_req_c && !ifu_req_c) begin
      winner_c = MID_LSU;
    end else if (lsu_req_c && ifu_req_c) begin
      if (ROUND_ROBIN == 0) winner_c = MID_LSU;
      else                  winner_c = (rr_last_q == MID_IFU) ? MID_LSU : MID_IFU;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_q     <= MID_IFU;
      rr_last_q   <= MID_IFU;
      err_wr_q    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_last_q   <= rr_last_d;
      err_wr_q    <= err_wr_d;
      timeout_err <= timeout_err | err_set_c;
    end
  end

  // Completion is checked before the watchdog so it wins a same-cycle tie.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_last_d = rr_last_q;
    err_wr_d  = err_wr_q;
    err_set_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (ifu_req_c || lsu_req_c) begin
          grant_d   = winner_c;
          rr_last_d = winner_c;
          if (winner_c == MID_IFU) state_d = IFU_RD;
          else                     state_d = lsu.arvalid ? LSU_RD : LSU_WR;
        end
      end
      IFU_RD, LSU_RD: begin
        if (rd_done_c) begin
          state_d = IDLE;
        end else if (fire_c) begin
          state_d   = ERR_RESP;
          err_wr_d  = 1'b0;
          err_set_c = 1'b1;
        end
      end
      LSU_WR: begin
        if (wr_done_c) begin
          state_d = IDLE;
        end else if (fire_c) begin
          state_d   = ERR_RESP;
          err_wr_d  = 1'b1;
          err_set_c = 1'b1;
        end
      end
      ERR_RESP: begin
        if (err_ack_c) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Grant mux: pure pass-through of the granted master, synthetic reply in ERR_RESP.
  always_comb begin
    mem.araddr  = '0;
    mem.arsize  = '0;
    mem.arvalid = 1'b0;
    mem.rready  = 1'b0;
    mem.awaddr  = '0;
    mem.awsize  = '0;
    mem.awvalid = 1'b0;
    mem.wdata   = '0;
    mem.wstrb   = '0;
    mem.wvalid  = 1'b0;
    mem.bready  = 1'b0;
    ifu.arready = 1'b0;
    ifu.rdata   = '0;
    ifu.rresp   = RESP_OKAY;
    ifu.rvalid  = 1'b0;
    lsu.arready = 1'b0;
    lsu.rdata   = '0;
    lsu.rresp   = RESP_OKAY;
    lsu.rvalid  = 1'b0;
    lsu.awready = 1'b0;
    lsu.wready  = 1'b0;
    lsu.bresp   = RESP_OKAY;
    lsu.bvalid  = 1'b0;
    case (state_q)
      IFU_RD: begin
        mem.araddr  = ifu.araddr;
        mem.arsize  = ifu.arsize;
        mem.arvalid = ifu.arvalid;
        ifu.arready = mem.arready;
        ifu.rdata   = mem.rdata;
        ifu.rresp   = mem.rresp;
        ifu.rvalid  = mem.rvalid;
        mem.rready  = ifu.rready;
      end
      LSU_RD: begin
        mem.araddr  = lsu.araddr;
        mem.arsize  = lsu.arsize;
        mem.arvalid = lsu.arvalid;
        lsu.arready = mem.arready;
        lsu.rdata   = mem.rdata;
        lsu.rresp   = mem.rresp;
        lsu.rvalid  = mem.rvalid;
        mem.rready  = lsu.rready;
      end
      LSU_WR: begin
        mem.awaddr  = lsu.awaddr;
        mem.awsize  = lsu.awsize;
        mem.awvalid = lsu.awvalid;
        lsu.awready = mem.awready;
        mem.wdata   = lsu.wdata;
        mem.wstrb   = lsu.wstrb;
        mem.wvalid  = lsu.wvalid;
        lsu.wready  = mem.wready;
        lsu.bresp   = mem.bresp;
        lsu.bvalid  = mem.bvalid;
        mem.bready  = lsu.bready;
      end
      ERR_RESP: begin
        if (err_wr_q) begin
          lsu.bvalid = 1'b1;
          lsu.bresp  = RESP_SLVERR;
        end else if (grant_q == MID_IFU) begin
          ifu.rvalid = 1'b1;
          ifu.rresp  = RESP_SLVERR;
        end else begin
          lsu.rvalid = 1'b1;
          lsu.rresp  = RESP_SLVERR;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ysyx_24110015_axi_arbiter.sv
// Directed bench: fixed-priority instance g_dut[0] and round-robin instance g_dut[1]
// share stimulus; each check names the instance it looks at.
module tb_ysyx_24110015_axi_arbiter;
  import ysyx_24110015_bus_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        i_arvalid, i_rready;
  logic [31:0] i_araddr;
  logic        l_arvalid, l_rready, l_awvalid, l_wvalid, l_bready;
  logic [31:0] l_araddr, l_awaddr, l_wdata;
  logic [3:0]  l_wstrb;
  logic        m_arready, m_rvalid, m_awready, m_wready, m_bvalid;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp, m_bresp;

  int checks   = 0;
  int failures = 0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    axi_lite_if ifu();
    axi_lite_if lsu();
    axi_lite_if mem();
    logic terr;

    assign ifu.araddr  = i_araddr;   assign ifu.arsize = 3'd2;      assign ifu.arvalid = i_arvalid;
    assign ifu.rready  = i_rready;   assign ifu.awaddr = '0;        assign ifu.awsize  = '0;
    assign ifu.awvalid = 1'b0;       assign ifu.wdata  = '0;        assign ifu.wstrb   = '0;
    assign ifu.wvalid  = 1'b0;       assign ifu.bready = 1'b0;
    assign lsu.araddr  = l_araddr;   assign lsu.arsize = 3'd2;      assign lsu.arvalid = l_arvalid;
    assign lsu.rready  = l_rready;   assign lsu.awaddr = l_awaddr;  assign lsu.awsize  = 3'd2;
    assign lsu.awvalid = l_awvalid;  assign lsu.wdata  = l_wdata;   assign lsu.wstrb   = l_wstrb;
    assign lsu.wvalid  = l_wvalid;   assign lsu.bready = l_bready;
    assign mem.arready = m_arready;  assign mem.rdata  = m_rdata;   assign mem.rresp   = m_rresp;
    assign mem.rvalid  = m_rvalid;   assign mem.awready = m_awready; assign mem.wready = m_wready;
    assign mem.bresp   = m_bresp;    assign mem.bvalid = m_bvalid;

    ysyx_24110015_axi_arbiter #(
      .ROUND_ROBIN (g),
      .TIMEOUT     (16),
      .CNT_W       (5)
    ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .ifu         (ifu),
      .lsu         (lsu),
      .mem         (mem),
      .timeout_err (terr)
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {arready, rvalid, rdata} seen by one master of one instance
  function automatic logic [33:0] peek(input int d, input bit ifu_side);
    if (d == 0) return ifu_side ? {g_dut[0].ifu.arready, g_dut[0].ifu.rvalid, g_dut[0].ifu.rdata}
                                : {g_dut[0].lsu.arready, g_dut[0].lsu.rvalid, g_dut[0].lsu.rdata};
    return ifu_side ? {g_dut[1].ifu.arready, g_dut[1].ifu.rvalid, g_dut[1].ifu.rdata}
                    : {g_dut[1].lsu.arready, g_dut[1].lsu.rvalid, g_dut[1].lsu.rdata};
  endfunction

  // Accept the pending ar this cycle, return data next cycle; checks the other master stays quiet.
  task automatic serve_rd(input string tag, input int d, input bit ifu_side, input logic [31:0] data);
    logic [33:0] p, q;
    m_arready = 1'b1;
    #1;
    p = peek(d, ifu_side);
    q = peek(d, !ifu_side);
    chk({tag, ".arready"}, 32'(p[33]), 32'd1);
    chk({tag, ".other_arready"}, 32'(q[33]), 32'd0);
    tick();
    m_arready = 1'b0;
    if (ifu_side) i_arvalid = 1'b0;
    else          l_arvalid = 1'b0;
    m_rvalid = 1'b1;
    m_rdata  = data;
    #1;
    p = peek(d, ifu_side);
    q = peek(d, !ifu_side);
    chk({tag, ".rvalid"}, 32'(p[32]), 32'd1);
    chk({tag, ".rdata"}, p[31:0], data);
    chk({tag, ".other_rvalid"}, 32'(q[32]), 32'd0);
    tick();
    m_rvalid = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    i_arvalid = 1'b0; i_rready = 1'b0; i_araddr = '0;
    l_arvalid = 1'b0; l_rready = 1'b0; l_awvalid = 1'b0; l_wvalid = 1'b0; l_bready = 1'b0;
    l_araddr = '0; l_awaddr = '0; l_wdata = '0; l_wstrb = '0;
    m_arready = 1'b0; m_rvalid = 1'b0; m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0;
    m_rdata = '0; m_rresp = 2'b00; m_bresp = 2'b00;
    tick();
    tick();
    #1;
    chk("rst.state", 32'(g_dut[0].u_dut.state_q), 32'(IDLE));
    chk("rst.mem_arvalid", 32'(g_dut[0].mem.arvalid), 32'd0);
    chk("rst.mem_awvalid", 32'(g_dut[0].mem.awvalid), 32'd0);
    chk("rst.mem_wvalid", 32'(g_dut[0].mem.wvalid), 32'd0);
    chk("rst.ifu_rvalid", 32'(g_dut[0].ifu.rvalid), 32'd0);
    chk("rst.lsu_bvalid", 32'(g_dut[0].lsu.bvalid), 32'd0);
    chk("rst.timeout_err", 32'(g_dut[0].terr), 32'd0);

    // Lone IFU fetch, arready two cycles after the grant
    rst = 1'b0;
    i_arvalid = 1'b1; i_araddr = 32'h8000_0000; i_rready = 1'b1;
    #1;
    chk("ifu1.idle_arvalid", 32'(g_dut[0].mem.arvalid), 32'd0);
    chk("ifu1.idle_arready", 32'(g_dut[0].ifu.arready), 32'd0);
    tick();
    #1;
    chk("ifu1.state", 32'(g_dut[0].u_dut.state_q), 32'(IFU_RD));
    chk("ifu1.mem_araddr", g_dut[0].mem.araddr, 32'h8000_0000);
    chk("ifu1.mem_arvalid", 32'(g_dut[0].mem.arvalid), 32'd1);
    tick();
    tick();
    serve_rd("ifu1", 0, 1'b1, 32'hDEAD_BEEF);
    chk("ifu1.done_state", 32'(g_dut[0].u_dut.state_q), 32'(IDLE));

    // Same-cycle IFU/LSU reads, fixed priority: LSU then IFU
    i_arvalid = 1'b1; i_araddr = 32'h8000_0010;
    l_arvalid = 1'b1; l_araddr = 32'h0F00_0000; l_rready = 1'b1;
    tick();
    #1;
    chk("fp.first_state", 32'(g_dut[0].u_dut.state_q), 32'(LSU_RD));
    chk("fp.first_araddr", g_dut[0].mem.araddr, 32'h0F00_0000);
    serve_rd("fp.lsu", 0, 1'b0, 32'h1111_1111);
    chk("fp.gap_state", 32'(g_dut[0].u_dut.state_q), 32'(IDLE));
    tick();
    #1;
    chk("fp.second_state", 32'(g_dut[0].u_dut.state_q), 32'(IFU_RD));
    chk("fp.second_araddr", g_dut[0].mem.araddr, 32'h8000_0010);
    serve_rd("fp.ifu", 0, 1'b1, 32'h2222_2222);

    // LSU store: awready in write cycle 1, wready in cycle 3
    l_awvalid = 1'b1; l_awaddr = 32'h0F00_0004;
    l_wvalid = 1'b1; l_wdata = 32'h1234_5678; l_wstrb = 4'b1111; l_bready = 1'b1;
    #1;
    chk("sw.idle_awready", 32'(g_dut[0].lsu.awready), 32'd0);
    tick();
    m_awready = 1'b1;
    #1;
    chk("sw.state", 32'(g_dut[0].u_dut.state_q), 32'(LSU_WR));
    chk("sw.mem_awaddr", g_dut[0].mem.awaddr, 32'h0F00_0004);
    chk("sw.lsu_awready", 32'(g_dut[0].lsu.awready), 32'd1);
    chk("sw.lsu_wready_c1", 32'(g_dut[0].lsu.wready), 32'd0);
    tick();
    l_awvalid = 1'b0; m_awready = 1'b0;
    #1;
    chk("sw.c2_state", 32'(g_dut[0].u_dut.state_q), 32'(LSU_WR));
    chk("sw.c2_mem_awvalid", 32'(g_dut[0].mem.awvalid), 32'd0);
    chk("sw.c2_bvalid", 32'(g_dut[0].lsu.bvalid), 32'd0);
    tick();
    m_wready = 1'b1;
    #1;
    chk("sw.c3_wready", 32'(g_dut[0].lsu.wready), 32'd1);
    chk("sw.c3_wdata", g_dut[0].mem.wdata, 32'h1234_5678);
    chk("sw.c3_wstrb", 32'(g_dut[0].mem.wstrb), 32'hF);
    tick();
    l_wvalid = 1'b0; m_wready = 1'b0; m_bvalid = 1'b1; m_bresp = 2'b00;
    #1;
    chk("sw.bvalid", 32'(g_dut[0].lsu.bvalid), 32'd1);
    chk("sw.bresp", 32'(g_dut[0].lsu.bresp), 32'd0);
    chk("sw.mem_bready", 32'(g_dut[0].mem.bready), 32'd1);
    tick();
    m_bvalid = 1'b0;
    #1;
    chk("sw.done_state", 32'(g_dut[0].u_dut.state_q), 32'(IDLE));
    chk("sw.done_bvalid", 32'(g_dut[0].lsu.bvalid), 32'd0);

    // Response arrives on busy cycle 16, the very cycle the watchdog fires
    i_arvalid = 1'b1; i_araddr = 32'h8000_0020;
    tick();
    m_arready = 1'b1;
    tick();
    i_arvalid = 1'b0; m_arready = 1'b0;
    repeat (14) tick();
    m_rvalid = 1'b1; m_rdata = 32'hCAFE_F00D;
    #1;
    chk("tie.fire", 32'(g_dut[0].u_dut.fire_c), 32'd1);
    chk("tie.rvalid", 32'(g_dut[0].ifu.rvalid), 32'd1);
    chk("tie.rdata", g_dut[0].ifu.rdata, 32'hCAFE_F00D);
    tick();
    m_rvalid = 1'b0;
    #1;
    chk("tie.state", 32'(g_dut[0].u_dut.state_q), 32'(IDLE));
    chk("tie.timeout_err", 32'(g_dut[0].terr), 32'd0);

    // IFU read that memory never answers
    i_arvalid = 1'b1; i_araddr = 32'h8000_0030; i_rready = 1'b0;
    tick();
    repeat (15) tick();
    #1;
    chk("to.c16_state", 32'(g_dut[0].u_dut.state_q), 32'(IFU_RD));
    chk("to.c16_arvalid", 32'(g_dut[0].mem.arvalid), 32'd1);
    chk("to.c16_terr", 32'(g_dut[0].terr), 32'd0);
    tick();
    i_arvalid = 1'b0;
    #1;
    chk("to.state", 32'(g_dut[0].u_dut.state_q), 32'(ERR_RESP));
    chk("to.mem_arvalid", 32'(g_dut[0].mem.arvalid), 32'd0);
    chk("to.rvalid", 32'(g_dut[0].ifu.rvalid), 32'd1);
    chk("to.rresp", 32'(g_dut[0].ifu.rresp), 32'h2);
    chk("to.rdata", g_dut[0].ifu.rdata, 32'h0);
    chk("to.terr", 32'(g_dut[0].terr), 32'd1);
    chk("to.lsu_rvalid", 32'(g_dut[0].lsu.rvalid), 32'd0);
    tick();
    #1;
    chk("to.hold_state", 32'(g_dut[0].u_dut.state_q), 32'(ERR_RESP));
    i_rready = 1'b1;
    tick();
    #1;
    chk("to.ack_state", 32'(g_dut[0].u_dut.state_q), 32'(IDLE));
    chk("to.ack_rvalid", 32'(g_dut[0].ifu.rvalid), 32'd0);
    tick();
    #1;
    chk("to.sticky", 32'(g_dut[0].terr), 32'd1);

    // Reset in the middle of an LSU read
    l_arvalid = 1'b1; l_araddr = 32'h0F00_0008;
    tick();
    #1;
    chk("rstmid.state", 32'(g_dut[0].u_dut.state_q), 32'(LSU_RD));
    chk("rstmid.arvalid", 32'(g_dut[0].mem.arvalid), 32'd1);
    rst = 1'b1;
    tick();
    #1;
    chk("rstmid.after_state", 32'(g_dut[0].u_dut.state_q), 32'(IDLE));
    chk("rstmid.after_arvalid", 32'(g_dut[0].mem.arvalid), 32'd0);
    chk("rstmid.after_terr", 32'(g_dut[0].terr), 32'd0);
    rst = 1'b0; l_arvalid = 1'b0;
    tick();

    // Round robin (g_dut[1]): conflict -> LSU, IFU; lone LSU; conflict -> IFU, LSU
    i_arvalid = 1'b1; i_araddr = 32'h8000_0040;
    l_arvalid = 1'b1; l_araddr = 32'h0F00_000C;
    tick();
    #1;
    chk("rr1.first_state", 32'(g_dut[1].u_dut.state_q), 32'(LSU_RD));
    chk("rr1.first_araddr", g_dut[1].mem.araddr, 32'h0F00_000C);
    serve_rd("rr1.lsu", 1, 1'b0, 32'h3333_3333);
    tick();
    #1;
    chk("rr1.second_state", 32'(g_dut[1].u_dut.state_q), 32'(IFU_RD));
    serve_rd("rr1.ifu", 1, 1'b1, 32'h4444_4444);
    l_arvalid = 1'b1; l_araddr = 32'h0F00_0010;
    tick();
    #1;
    chk("rr.lone_state", 32'(g_dut[1].u_dut.state_q), 32'(LSU_RD));
    serve_rd("rr.lone", 1, 1'b0, 32'h5555_5555);
    i_arvalid = 1'b1; i_araddr = 32'h8000_0044;
    l_arvalid = 1'b1; l_araddr = 32'h0F00_0014;
    tick();
    #1;
    chk("rr2.first_state", 32'(g_dut[1].u_dut.state_q), 32'(IFU_RD));
    chk("rr2.first_araddr", g_dut[1].mem.araddr, 32'h8000_0044);
    serve_rd("rr2.ifu", 1, 1'b1, 32'h6666_6666);
    tick();
    #1;
    chk("rr2.second_state", 32'(g_dut[1].u_dut.state_q), 32'(LSU_RD));
    chk("rr2.second_araddr", g_dut[1].mem.araddr, 32'h0F00_0014);
    serve_rd("rr2.lsu", 1, 1'b0, 32'h7777_7777);
    chk("rr2.done_state", 32'(g_dut[1].u_dut.state_q), 32'(IDLE));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
